// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: buffer load/flush enables
// from cache handshakes, load-use and taken-branch hazards, plus stall counters.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_uses_rs2,
    input  logic             br_taken,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] hazard_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    logic [0:0] state_reg, state_next;
    logic       i_done_reg, i_done_next;
    logic       d_done_reg, d_done_next;

    logic i_ok, d_ok, advance;
    logic rs1_match, rs2_match, load_use, branch;

    assign i_ok    = !imem_read | imem_resp | i_done_reg;
    assign d_ok    = !dmem_req  | dmem_resp | d_done_reg;
    assign advance = i_ok & d_ok;

    assign rs1_match = (id_ex_rd == if_id_rs1);
    assign rs2_match = if_id_uses_rs2 & (id_ex_rd == if_id_rs2);
    assign load_use  = id_ex_memread & (id_ex_rd != 5'd0) & (rs1_match | rs2_match);
    assign branch    = br_taken;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:      if (!advance) state_next = MEM_WAIT;
            MEM_WAIT: if (advance)  state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    // Responses without a matching request never set a flag.
    always_comb begin
        i_done_next = i_done_reg;
        d_done_next = d_done_reg;
        if (advance) begin
            i_done_next = 1'b0;
            d_done_next = 1'b0;
        end else begin
            if (imem_read & imem_resp) i_done_next = 1'b1;
            if (dmem_req & dmem_resp)  d_done_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= RUN;
            i_done_reg <= 1'b0;
            d_done_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            i_done_reg <= i_done_next;
            d_done_reg <= d_done_next;
        end
    end

    // Branch outranks load-use: the flush discards the dependent instruction anyway.
    always_comb begin
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (rst && advance) begin
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            if (branch) begin
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (load_use) begin
                flush_id_ex = 1'b1;
            end else begin
                load_pc    = 1'b1;
                load_if_id = 1'b1;
            end
        end
    end

    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [3];

    assign cnt_inc[0] = !advance;
    assign cnt_inc[1] = advance & load_use & !branch;
    assign cnt_inc[2] = advance & branch;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gen_cnt
            logic [CNT_W-1:0] count_reg;
            always_ff @(posedge clk) begin
                if (!rst)
                    count_reg <= '0;
                else if (cnt_inc[gi] && (count_reg != {CNT_W{1'b1}}))
                    count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            assign cnt_val[gi] = count_reg;
        end
    endgenerate

    assign mem_stall_cnt    = cnt_val[0];
    assign hazard_stall_cnt = cnt_val[1];
    assign flush_cnt        = cnt_val[2];

endmodule
